// File: rtl/ex_issue_stage.sv
// ex_issue_stage
//   ID/EX stage feeding the execute-stage ALU. Captures decoded operands and
//   control from decode. Single-cycle ops are presented to the ALU for one
//   cycle. Mul/div (func 1000/1001) hold frozen operands for MULDIV_LAT
//   cycles while stalling the front end, then flag the result as valid.
//
//   Optional feature macro: FORWARD_EN
//     defined   - EX/MEM and MEM/WB forwarding muxes on both operands
//                 (EX/MEM has priority, register 0 never forwarded,
//                 immediates never forwarded).
//     undefined - operands come only from id_rs_val / id_rt_val; the
//                 exmem_* / memwb_* inputs are ignored.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   id_valid            decode presents an instruction
//   id_rs_val/id_rt_val register-file reads (rt may carry an immediate)
//   id_rs/id_rt         source register numbers
//   id_use_imm          operand 2 is an immediate
//   id_rd/id_reg_write  destination register and its write enable
//   id_alu_ctrl/id_func ALU operation code and function field
//   flush               kill the instruction held in EX
//   exmem_*/memwb_*     later-stage destination, write enable and result
//   stall               hold IF/ID; decode keeps its outputs stable
//   alu_in1/alu_in2     ALU operands
//   alu_ctrl/alu_func   ALU control
//   ex_rd/ex_reg_write  destination and write enable for EX/MEM
//   ex_valid            EX/MEM captures the ALU result this cycle
module ex_issue_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int MULDIV_LAT = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic [2:0]        id_alu_ctrl,
  input  logic [3:0]        id_func,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              exmem_wr,
  input  logic              memwb_wr,
  input  logic [DATA_W-1:0] exmem_val,
  input  logic [DATA_W-1:0] memwb_val,
  output logic              stall,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_ctrl,
  output logic [3:0]        alu_func,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_valid
);

  localparam int               CNT_W    = $clog2(MULDIV_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, EXEC, BUSY} state_t;

  state_t                    state_p1, state_nxt;
  logic [CNT_W-1:0]          cnt_p1, cnt_nxt;
  logic                      first_p1, first_nxt;
  logic                      load;
  logic                      is_muldiv;

  logic signed [DATA_W-1:0]  rs_val_p1, rt_val_p1;
  logic signed [DATA_W-1:0]  hold1_p1, hold2_p1;
  logic signed [DATA_W-1:0]  op1_fwd, op2_fwd;
  logic [REG_AW-1:0]         rd_p1;
  logic                      reg_write_p1;
  logic [2:0]                ctrl_p1;
  logic [3:0]                func_p1;

`ifdef FORWARD_EN
  logic [REG_AW-1:0]         rs_p1, rt_p1;
  logic                      use_imm_p1;
`else
  logic                      unused_fwd_inputs;
  assign unused_fwd_inputs = ^{id_rs, id_rt, id_use_imm, exmem_rd, memwb_rd,
                               exmem_wr, memwb_wr, exmem_val, memwb_val};
`endif

  assign is_muldiv = (id_func == 4'b1000) || (id_func == 4'b1001);

  // Next-state and control outputs
  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    first_nxt = 1'b0;
    stall     = (state_p1 == BUSY) && (cnt_p1 != '0);
    // A flush kills whatever sits in EX, including a result in its last cycle.
    ex_valid  = ((state_p1 == EXEC) || ((state_p1 == BUSY) && (cnt_p1 == '0))) && !flush;
    // Bubbles and flushed captures leave the held fields untouched.
    load      = !stall && id_valid && !flush;
    if (stall) begin
      if (flush) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_p1 - CNT_ONE;
      end
    end else if (load) begin
      first_nxt = 1'b1;
      if (is_muldiv) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_LOAD;
      end else begin
        state_nxt = EXEC;
        cnt_nxt   = '0;
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Operand forwarding against the captured source registers
  always_comb begin
    op1_fwd = rs_val_p1;
    op2_fwd = rt_val_p1;
`ifdef FORWARD_EN
    if (rs_p1 != '0) begin
      if (exmem_wr && (exmem_rd == rs_p1))
        op1_fwd = $signed(exmem_val);
      else if (memwb_wr && (memwb_rd == rs_p1))
        op1_fwd = $signed(memwb_val);
    end
    if (!use_imm_p1 && (rt_p1 != '0)) begin
      if (exmem_wr && (exmem_rd == rt_p1))
        op2_fwd = $signed(exmem_val);
      else if (memwb_wr && (memwb_rd == rt_p1))
        op2_fwd = $signed(memwb_val);
    end
`endif
  end

  // ---- ID/EX boundary: capture, counter and operand hold registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1     <= IDLE;
      cnt_p1       <= '0;
      first_p1     <= 1'b0;
      rs_val_p1    <= '0;
      rt_val_p1    <= '0;
      hold1_p1     <= '0;
      hold2_p1     <= '0;
      rd_p1        <= '0;
      reg_write_p1 <= 1'b0;
      ctrl_p1      <= '0;
      func_p1      <= '0;
`ifdef FORWARD_EN
      rs_p1        <= '0;
      rt_p1        <= '0;
      use_imm_p1   <= 1'b0;
`endif
    end else begin
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      first_p1 <= first_nxt;
      if (load) begin
        rs_val_p1    <= $signed(id_rs_val);
        rt_val_p1    <= $signed(id_rt_val);
        rd_p1        <= id_rd;
        reg_write_p1 <= id_reg_write;
        ctrl_p1      <= id_alu_ctrl;
        func_p1      <= id_func;
`ifdef FORWARD_EN
        rs_p1        <= id_rs;
        rt_p1        <= id_rt;
        use_imm_p1   <= id_use_imm;
`endif
      end
      // Later stages drain during a mul/div stall, so the operands resolved
      // in the first EX cycle are frozen here for the rest of the occupancy.
      if (first_p1) begin
        hold1_p1 <= op1_fwd;
        hold2_p1 <= op2_fwd;
      end
    end
  end

  // ---- EX outputs to the ALU and EX/MEM ----
  assign alu_in1      = first_p1 ? op1_fwd : hold1_p1;
  assign alu_in2      = first_p1 ? op2_fwd : hold2_p1;
  assign alu_ctrl     = ctrl_p1;
  assign alu_func     = func_p1;
  assign ex_rd        = rd_p1;
  assign ex_reg_write = reg_write_p1 && ex_valid;

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int LAT    = 17;
`ifdef FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, id_valid, id_use_imm, id_reg_write, flush;
  logic [DATA_W-1:0] id_rs_val, id_rt_val, exmem_val, memwb_val;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic              exmem_wr, memwb_wr;
  logic [2:0]        id_alu_ctrl;
  logic [3:0]        id_func;
  logic              stall, ex_reg_write, ex_valid;
  logic [DATA_W-1:0] alu_in1, alu_in2;
  logic [2:0]        alu_ctrl;
  logic [3:0]        alu_func;
  logic [REG_AW-1:0] ex_rd;

  ex_issue_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_alu_ctrl(id_alu_ctrl), .id_func(id_func), .flush(flush),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
    .exmem_val(exmem_val), .memwb_val(memwb_val),
    .stall(stall), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_func(alu_func), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dut_done = 0;

  // Transaction-level model: the instruction in EX, how many EX cycles it
  // has spent, how many it needs, and the operands it resolved on entry.
  bit                m_occ, m_fresh;
  int                m_age, m_lat;
  logic [DATA_W-1:0] m_rsv, m_rtv, m_op1, m_op2, m_last1, m_last2;
  logic [REG_AW-1:0] m_rs, m_rt, m_rd;
  logic              m_imm, m_rw;
  logic [2:0]        m_ctrl;
  logic [3:0]        m_func;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pick(input logic [REG_AW-1:0] src,
                                            input logic [DATA_W-1:0] own, input bit allow);
    if (FWD_ON && allow && src != '0) begin
      if (exmem_wr && exmem_rd == src) return exmem_val;
      if (memwb_wr && memwb_rd == src) return memwb_val;
    end
    return own;
  endfunction

  task automatic model_reset();
    m_occ = 0; m_fresh = 1; m_age = 0; m_lat = 1;
    m_last1 = '0; m_last2 = '0; m_op1 = '0; m_op2 = '0;
    m_rd = '0; m_ctrl = '0; m_func = '0; m_rw = 0;
  endtask

  task automatic set_id(input logic v, input logic [DATA_W-1:0] rsv, input logic [DATA_W-1:0] rtv,
                        input int rs, input int rt, input logic imm, input int rd,
                        input logic rw, input int ctrl, input int func);
    id_valid = v; id_rs_val = rsv; id_rt_val = rtv;
    id_rs = REG_AW'(rs); id_rt = REG_AW'(rt); id_use_imm = imm;
    id_rd = REG_AW'(rd); id_reg_write = rw;
    id_alu_ctrl = 3'(ctrl); id_func = 4'(func);
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1; flush = 1'b0; exmem_wr = 1'b0; memwb_wr = 1'b0;
  endtask

  task automatic end_cycle();
    logic es, ev;
    logic [DATA_W-1:0] e1, e2;
    es = m_occ && (m_age < m_lat);
    ev = m_occ && (m_age == m_lat) && !flush;
    if (m_occ && m_age == 1) begin
      m_op1 = pick(m_rs, m_rsv, 1'b1);
      m_op2 = pick(m_rt, m_rtv, !m_imm);
    end
    e1 = m_occ ? m_op1 : m_last1;
    e2 = m_occ ? m_op2 : m_last2;
    @(negedge clk);
    chk("stall", stall, es);
    chk("ex_valid", ex_valid, ev);
    chk("ex_reg_write", ex_reg_write, ev & m_rw);
    chk("alu_in1", alu_in1, e1);
    chk("alu_in2", alu_in2, e2);
    if (m_occ || m_fresh) begin
      chk("alu_ctrl", alu_ctrl, m_ctrl);
      chk("alu_func", alu_func, m_func);
      chk("ex_rd", ex_rd, m_rd);
    end
    if (ex_valid === 1'b1) dut_done++;
    // Model update for the coming edge
    if (m_occ && m_age == 1) begin m_last1 = m_op1; m_last2 = m_op2; end
    if (!rst_n) begin
      model_reset();
    end else if (es) begin
      m_fresh = 0;
      if (flush) m_occ = 0; else m_age++;
    end else begin
      m_fresh = 0;
      if (id_valid && !flush) begin
        m_occ = 1; m_age = 1;
        m_lat = (id_func == 4'd8 || id_func == 4'd9) ? LAT : 1;
        m_rsv = id_rs_val; m_rtv = id_rt_val; m_rs = id_rs; m_rt = id_rt;
        m_imm = id_use_imm; m_rd = id_rd; m_rw = id_reg_write;
        m_ctrl = id_alu_ctrl; m_func = id_func;
      end else begin
        m_occ = 0;
      end
    end
  endtask

  initial begin
    int done0;
    bit stalled;
    rst_n = 0; flush = 0; exmem_wr = 0; memwb_wr = 0;
    exmem_rd = '0; memwb_rd = '0; exmem_val = '0; memwb_val = '0;
    set_id(0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held one more cycle, then reset state is observed
    start_cycle(); rst_n = 0; end_cycle();
    start_cycle(); end_cycle();

    // Single-cycle add: rs_val 5, rt_val 7, rd 2
    done0 = dut_done;
    start_cycle(); set_id(1, 16'd5, 16'd7, 1, 4, 0, 2, 1, 0, 0); end_cycle();
    start_cycle(); set_id(0, '0, '0, 0, 0, 0, 0, 0, 0, 0); end_cycle();
    start_cycle(); end_cycle();
    chk("add_done", dut_done - done0, 1);

    // mul followed back-to-back by div, then an add; later stages keep
    // targeting the mul's source to prove the operands stay frozen
    done0 = dut_done;
    start_cycle(); set_id(1, 16'h1234, 16'h0042, 3, 5, 0, 6, 1, 2, 8); end_cycle();
    start_cycle(); set_id(1, 16'h0F00, 16'h0003, 2, 7, 0, 1, 1, 3, 9);
    exmem_wr = 1; exmem_rd = 3'd3; exmem_val = 16'h00AA; end_cycle();
    for (int k = 2; k <= LAT; k++) begin
      start_cycle();
      exmem_wr = 1; exmem_rd = 3'd3; exmem_val = 16'($urandom);
      memwb_wr = 1; memwb_rd = 3'd5; memwb_val = 16'($urandom);
      end_cycle();
    end
    start_cycle(); set_id(1, 16'h0100, 16'h0200, 1, 2, 0, 4, 0, 1, 0); end_cycle();
    for (int k = 2; k <= LAT; k++) begin start_cycle(); end_cycle(); end
    start_cycle(); set_id(0, '0, '0, 0, 0, 0, 0, 0, 0, 0); end_cycle();
    start_cycle(); end_cycle();
    chk("muldiv_done", dut_done - done0, 3);

    // Forwarding: EX/MEM beats MEM/WB, r0 never forwarded, immediate never forwarded
    start_cycle(); set_id(1, 16'h1111, 16'h2222, 3, 5, 0, 1, 1, 0, 0); end_cycle();
    start_cycle(); set_id(1, 16'h3333, 16'h4444, 0, 5, 0, 1, 1, 0, 0);
    exmem_wr = 1; exmem_rd = 3'd3; exmem_val = 16'h00AA;
    memwb_wr = 1; memwb_rd = 3'd3; memwb_val = 16'h0055; end_cycle();
    chk("fwd_rs3", alu_in1, FWD_ON ? 16'h00AA : 16'h1111);
    start_cycle(); set_id(1, 16'h5555, 16'hFFF6, 1, 6, 1, 1, 1, 0, 0);
    exmem_wr = 1; exmem_rd = 3'd0; exmem_val = 16'h00AA;
    memwb_wr = 1; memwb_rd = 3'd0; memwb_val = 16'h0055; end_cycle();
    chk("fwd_rs0", alu_in1, 16'h3333);
    start_cycle(); set_id(0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
    exmem_wr = 1; exmem_rd = 3'd6; exmem_val = 16'h00AA; end_cycle();
    chk("fwd_imm", alu_in2, 16'hFFF6);

    // div flushed in its 5th BUSY cycle
    done0 = dut_done;
    start_cycle(); set_id(1, 16'h0777, 16'h0007, 1, 2, 0, 3, 1, 4, 9); end_cycle();
    start_cycle(); set_id(0, '0, '0, 0, 0, 0, 0, 0, 0, 0); end_cycle();
    for (int k = 2; k <= 4; k++) begin start_cycle(); end_cycle(); end
    start_cycle(); flush = 1; end_cycle();
    for (int k = 0; k < LAT; k++) begin start_cycle(); end_cycle(); end
    chk("flush_done", dut_done - done0, 0);

    // Reset in the 8th BUSY cycle of a mul, then an add completes
    start_cycle(); set_id(1, 16'h0ABC, 16'h0DEF, 4, 5, 0, 7, 1, 5, 8); end_cycle();
    start_cycle(); set_id(0, '0, '0, 0, 0, 0, 0, 0, 0, 0); end_cycle();
    for (int k = 2; k <= 7; k++) begin start_cycle(); end_cycle(); end
    start_cycle(); rst_n = 0; end_cycle();
    done0 = dut_done;
    start_cycle(); set_id(1, 16'd9, 16'd11, 1, 2, 0, 3, 1, 0, 0); end_cycle();
    chk("rst_alu_in1", alu_in1, 0);
    start_cycle(); set_id(0, '0, '0, 0, 0, 0, 0, 0, 0, 0); end_cycle();
    chk("post_rst_add", alu_in1, 16'd9);
    chk("post_rst_done", dut_done - done0, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      start_cycle();
      stalled = m_occ && (m_age < m_lat);
      exmem_wr = 1'($urandom); exmem_rd = REG_AW'($urandom); exmem_val = DATA_W'($urandom);
      memwb_wr = 1'($urandom); memwb_rd = REG_AW'($urandom); memwb_val = DATA_W'($urandom);
      if (!stalled) begin
        set_id(($urandom_range(0, 3) != 0), DATA_W'($urandom), DATA_W'($urandom),
               $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
               $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
               ($urandom_range(0, 3) == 0) ? $urandom_range(8, 9) : $urandom_range(0, 15));
      end
      flush = m_occ && ($urandom_range(0, 39) == 0);
      if (flush && !stalled) id_valid = 0;
      rst_n = ($urandom_range(0, 299) != 0);
      end_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
